stopwatch_lap_core: RTL and testbench

Parametrised stopwatch core. It generates its own hundredths tick from the board clock and keeps an M:SS.CC BCD time with a start/pause/idle state machine. A lap memory of configurable depth captures split times, in either stop-when-full or ring-overwrite mode. It also time-multiplexes either the live time or a selected lap onto the 4-digit seven-segment scan. Inputs are single-cycle synchronous pulses from the board debouncer. The 7-segment decode stays in the existing hex7seg downstream.

---
 rtl/stopwatch_pkg.sv | 33 +++
 rtl/sw_tick_gen.sv | 26 ++
 rtl/stopwatch_lap_core.sv | 155 +++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: BCD time word, FSM states, digit limits.
package stopwatch_pkg;

   typedef struct packed {
      logic [3:0] min;
      logic [3:0] s1;
      logic [3:0] s0;
      logic [3:0] dec;
      logic [3:0] cen;
   } sw_time_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_e;

   localparam logic [3:0] CEN_MAX = 4'd9;
   localparam logic [3:0] DEC_MAX = 4'd9;
   localparam logic [3:0] S0_MAX  = 4'd9;
   localparam logic [3:0] S1_MAX  = 4'd5;

   localparam sw_time_t ZERO_TIME = '0;

   // Thermometer code of the minute count: bit i set when minutes exceed i.
   function automatic logic [7:0] min_therm(input logic [3:0] m);
      logic [7:0] t;
      t = '0;
      for (int i = 0; i < 8; i++) t[i] = (m > 4'(i));
      return t;
   endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// Hundredths prescaler: counts while enabled, holds otherwise, flags the terminal count.
module sw_tick_gen #(
   parameter int unsigned DIV = 500000
) (
   input  logic clk_50M,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned CNT_W = $clog2(DIV);

   logic [CNT_W-1:0] cnt_q;

   assign tick_c = en && (cnt_q == CNT_W'(DIV - 1));

   always_ff @(posedge clk_50M) begin
      if (reset || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: run/pause FSM, M:SS.CC BCD counter, lap memory and 4-digit scan mux.
module stopwatch_lap_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter int unsigned TICK_HZ   = 100,
   parameter int unsigned N_LAPS    = 4,
   parameter int unsigned LAP_MODE  = 0,
   parameter int unsigned MAX_MIN   = 9,
   parameter int unsigned SCAN_BITS = 13
) (
   input  logic                       clk_50M,
   input  logic                       reset,
   input  logic                       start_stop,
   input  logic                       lap,
   input  logic                       clear,
   input  logic                       view_en,
   input  logic [$clog2(N_LAPS)-1:0]  view_sel,
   output logic [3:0]                 digit_bcd,
   output logic [3:0]                 an,
   output logic                       dp,
   output logic                       running,
   output logic [$clog2(N_LAPS):0]    lap_count,
   output logic                       lap_full,
   output logic [7:0]                 min_leds
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = $clog2(N_LAPS);
   localparam int unsigned CW  = PW + 1;

   sw_state_e          state_q, state_d;
   sw_time_t           time_q, time_d;
   sw_time_t           laps_q [N_LAPS];
   logic [PW-1:0]      wr_ptr_q;
   logic [SCAN_BITS-1:0] scan_q;
   logic               tick_c;
   logic               lap_accept_c;
   logic [1:0]         pos_c;
   logic [PW-1:0]      slot_c;
   sw_time_t           src_c;
   logic [3:0]         digit_c;

   sw_tick_gen #(.DIV(DIV)) u_tick (
      .clk_50M (clk_50M),
      .reset   (reset),
      .clr     (clear),
      .en      (state_q == RUN),
      .tick_c  (tick_c)
   );

   // Next state; clear dominates start_stop.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else if (start_stop) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // BCD cascade; each digit rolls only when every lower digit is at its limit.
   always_comb begin
      time_d = time_q;
      if (clear) begin
         time_d = ZERO_TIME;
      end else if (tick_c) begin
         if (time_q.cen != CEN_MAX) begin
            time_d.cen = time_q.cen + 4'd1;
         end else begin
            time_d.cen = '0;
            if (time_q.dec != DEC_MAX) begin
               time_d.dec = time_q.dec + 4'd1;
            end else begin
               time_d.dec = '0;
               if (time_q.s0 != S0_MAX) begin
                  time_d.s0 = time_q.s0 + 4'd1;
               end else begin
                  time_d.s0 = '0;
                  if (time_q.s1 != S1_MAX) begin
                     time_d.s1 = time_q.s1 + 4'd1;
                  end else begin
                     time_d.s1  = '0;
                     time_d.min = (time_q.min == 4'(MAX_MIN)) ? 4'd0 : time_q.min + 4'd1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_50M) begin
      if (reset) begin
         state_q  <= IDLE;
         time_q   <= ZERO_TIME;
         running  <= 1'b0;
         min_leds <= '0;
      end else begin
         state_q  <= state_d;
         time_q   <= time_d;
         running  <= (state_d == RUN);
         min_leds <= min_therm(time_d.min);
      end
   end

   // A capture uses the pre-tick time_q, so a coincident tick is not seen.
   assign lap_accept_c = lap && !clear && (state_q != IDLE) && (!lap_full || LAP_MODE == 1);

   always_ff @(posedge clk_50M) begin
      if (reset || clear) begin
         for (int i = 0; i < int'(N_LAPS); i++) laps_q[i] <= ZERO_TIME;
         wr_ptr_q  <= '0;
         lap_count <= '0;
         lap_full  <= 1'b0;
      end else if (lap_accept_c) begin
         laps_q[wr_ptr_q] <= time_q;
         wr_ptr_q         <= wr_ptr_q + PW'(1);
         if (!lap_full) begin
            lap_count <= lap_count + CW'(1);
            lap_full  <= (lap_count == CW'(N_LAPS - 1));
         end
      end
   end

   assign pos_c = scan_q[SCAN_BITS-1 -: 2];

   // Source select; in a full ring the oldest lap sits at wr_ptr.
   always_comb begin
      slot_c = view_sel;
      if (LAP_MODE == 1 && lap_full) slot_c = wr_ptr_q + view_sel;
      src_c = time_q;
      if (view_en) src_c = (CW'(view_sel) < lap_count) ? laps_q[slot_c] : ZERO_TIME;
      digit_c = src_c[5'({pos_c, 2'b00}) +: 4];
   end

   always_ff @(posedge clk_50M) begin
      if (reset) begin
         scan_q    <= '0;
         digit_bcd <= '0;
         an        <= 4'b1110;
         dp        <= 1'b1;
      end else begin
         scan_q    <= scan_q + SCAN_BITS'(1);
         digit_bcd <= digit_c;
         an        <= ~(4'b0001 << pos_c);
         dp        <= (pos_c != 2'd2);
      end
   end

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Bench for stopwatch_lap_core: two configurations driven by shared stimulus, checked against a hundredths-count model.
module tb_stopwatch_lap_core;

   logic       clk_50M = 1'b0;
   logic       reset = 1'b1;
   logic       start_stop = 1'b0;
   logic       lap = 1'b0;
   logic       clear = 1'b0;
   logic       view_en = 1'b0;
   logic [1:0] view_sel = 2'd0;

   logic [3:0] a_digit, a_an, b_digit, b_an;
   logic       a_dp, a_running, a_full, b_dp, b_running, b_full;
   logic [2:0] a_cnt, b_cnt;
   logic [7:0] a_mled, b_mled;

   always #5 clk_50M = ~clk_50M;

   // A: 10 clocks per tick, stop-when-full, 9 minutes.  B: 2 clocks per tick, ring, 1 minute.
   stopwatch_lap_core #(.CLK_HZ(1000), .TICK_HZ(100), .N_LAPS(4), .LAP_MODE(0),
                        .MAX_MIN(9), .SCAN_BITS(4)) dut_a (
      .clk_50M(clk_50M), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
      .view_en(view_en), .view_sel(view_sel), .digit_bcd(a_digit), .an(a_an), .dp(a_dp),
      .running(a_running), .lap_count(a_cnt), .lap_full(a_full), .min_leds(a_mled));

   stopwatch_lap_core #(.CLK_HZ(200), .TICK_HZ(100), .N_LAPS(4), .LAP_MODE(1),
                        .MAX_MIN(1), .SCAN_BITS(4)) dut_b (
      .clk_50M(clk_50M), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
      .view_en(view_en), .view_sel(view_sel), .digit_bcd(b_digit), .an(b_an), .dp(b_dp),
      .running(b_running), .lap_count(b_cnt), .lap_full(b_full), .min_leds(b_mled));

   localparam int NL = 4;
   int divs [2] = '{10, 2};
   int modes[2] = '{0, 1};
   int tmax [2] = '{60000, 12000};

   // Model state: st 0=idle 1=run 2=pause; t = total hundredths; laps hold totals.
   int m_st[2], m_ph[2], m_t[2], m_wr[2], m_cnt[2], m_scan[2];
   int m_laps[2][NL];
   int e_dig[2], e_an[2], e_dp[2];

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int digit_of(input int t, input int pos);
      case (pos)
         0:       return t % 10;
         1:       return (t / 10) % 10;
         2:       return (t / 100) % 10;
         default: return (t / 1000) % 6;
      endcase
   endfunction

   function automatic int therm(input int m);
      int r = 0;
      for (int i = 0; i < 8; i++) if (m > i) r |= (1 << i);
      return r;
   endfunction

   task automatic model_step(input int k);
      int pos, src, slot;
      bit tk;
      if (reset) begin
         m_st[k] = 0; m_ph[k] = 0; m_t[k] = 0; m_wr[k] = 0; m_cnt[k] = 0; m_scan[k] = 0;
         for (int j = 0; j < NL; j++) m_laps[k][j] = 0;
         e_dig[k] = 0; e_an[k] = 4'hE; e_dp[k] = 1;
      end else begin
         pos = (m_scan[k] >> 2) & 3;
         src = m_t[k];
         if (view_en) begin
            src = 0;
            if (int'(view_sel) < m_cnt[k]) begin
               slot = (m_cnt[k] == NL && modes[k] == 1) ? (m_wr[k] + int'(view_sel)) % NL
                                                        : int'(view_sel);
               src = m_laps[k][slot];
            end
         end
         e_dig[k] = digit_of(src, pos);
         e_an[k]  = 4'hF ^ (1 << pos);
         e_dp[k]  = (pos != 2);
         m_scan[k] = (m_scan[k] + 1) % 16;
         if (clear) begin
            m_st[k] = 0; m_ph[k] = 0; m_t[k] = 0; m_wr[k] = 0; m_cnt[k] = 0;
            for (int j = 0; j < NL; j++) m_laps[k][j] = 0;
         end else begin
            tk = (m_st[k] == 1) && (m_ph[k] == divs[k] - 1);
            if (lap && m_st[k] != 0 && (m_cnt[k] < NL || modes[k] == 1)) begin
               m_laps[k][m_wr[k]] = m_t[k];
               m_wr[k] = (m_wr[k] + 1) % NL;
               if (m_cnt[k] < NL) m_cnt[k]++;
            end
            if (m_st[k] == 1) m_ph[k] = tk ? 0 : m_ph[k] + 1;
            if (tk) m_t[k] = (m_t[k] + 1) % tmax[k];
            if (start_stop) m_st[k] = (m_st[k] == 1) ? 2 : 1;
         end
      end
   endtask

   always @(posedge clk_50M) begin
      model_step(0);
      model_step(1);
   end

   task automatic cmp_dut(input string nm, input int k, input logic [3:0] dig, input logic [3:0] an_v,
                          input logic dp_v, input logic run_v, input logic [2:0] cnt_v,
                          input logic full_v, input logic [7:0] mled_v);
      chk({nm, ".digit_bcd"}, dig, e_dig[k]);
      chk({nm, ".an"}, an_v, e_an[k]);
      chk({nm, ".dp"}, dp_v, e_dp[k]);
      chk({nm, ".running"}, run_v, m_st[k] == 1);
      chk({nm, ".lap_count"}, cnt_v, m_cnt[k]);
      chk({nm, ".lap_full"}, full_v, m_cnt[k] == NL);
      chk({nm, ".min_leds"}, mled_v, therm(m_t[k] / 6000));
   endtask

   always @(negedge clk_50M) begin
      if (chk_en) begin
         cmp_dut("A", 0, a_digit, a_an, a_dp, a_running, a_cnt, a_full, a_mled);
         cmp_dut("B", 1, b_digit, b_an, b_dp, b_running, b_cnt, b_full, b_mled);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_50M);
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1; @(negedge clk_50M); start_stop = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1; @(negedge clk_50M); lap = 1'b0;
   endtask

   task automatic wait_t(input int k, input int target, input int budget, input string nm);
      int n = 0;
      while (m_t[k] != target && n < budget) begin @(negedge clk_50M); n++; end
      chk({nm, ".reached"}, m_t[k] == target, 1);
   endtask

   // Watch one full scan period and check each digit against the expected time t.
   task automatic check_disp(input int k, input int t, input string nm);
      logic [3:0] an_v, d_v, seen;
      logic       dp_v;
      int         exp_d, exp_dp;
      bit         ok;
      seen = '0;
      @(negedge clk_50M);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_50M);
         an_v = (k == 0) ? a_an : b_an;
         d_v  = (k == 0) ? a_digit : b_digit;
         dp_v = (k == 0) ? a_dp : b_dp;
         ok = 1'b1; exp_d = 0; exp_dp = 1;
         case (an_v)
            4'hE: begin exp_d = t % 10;          seen[0] = 1'b1; end
            4'hD: begin exp_d = (t / 10) % 10;   seen[1] = 1'b1; end
            4'hB: begin exp_d = (t / 100) % 10;  seen[2] = 1'b1; exp_dp = 0; end
            4'h7: begin exp_d = (t / 1000) % 6;  seen[3] = 1'b1; end
            default: ok = 1'b0;
         endcase
         chk({nm, ".an_onehot"}, ok, 1);
         chk({nm, ".digit"}, d_v, exp_d);
         chk({nm, ".dp"}, dp_v, exp_dp);
      end
      chk({nm, ".an_cycle"}, seen, 4'hF);
   endtask

   int lapt_a[7], lapt_b[7];
   int pre, g;

   initial begin
      @(negedge clk_50M);
      chk_en = 1'b1;
      chk("reset.an", a_an, 4'hE);
      chk("reset.digit", a_digit, 0);
      chk("reset.dp", a_dp, 1);
      chk("reset.running", a_running, 0);
      chk("reset.lap_count", a_cnt, 0);
      chk("reset.min_leds", a_mled, 0);
      cyc(2);
      reset = 1'b0;
      @(negedge clk_50M);

      // Run 995 ticks of A (10 clocks each) -> 0:09.95.
      pulse_ss();
      cyc(9950);
      chk("run995.model_t", m_t[0], 995);
      chk("run995.running", a_running, 1);

      pulse_ss();
      cyc(200);
      chk("pause.running", a_running, 0);
      chk("pause.model_t", m_t[0], 995);
      check_disp(0, 995, "pause.disp");

      // Prescaler was left at phase 1, so the next tick lands 9 clocks after resume.
      pulse_ss();
      cyc(8);
      chk("resume.before_tick", m_t[0], 995);
      cyc(1);
      chk("resume.phase_kept", m_t[0], 996);

      wait_t(1, 11999, 40000, "B.1:59.99");
      chk("B.min_leds_1", b_mled, 8'h01);
      cyc(2);
      chk("B.wrap_t", m_t[1], 0);
      chk("B.wrap_min_leds", b_mled, 8'h00);

      wait_t(0, 5999, 60000, "A.0:59.99");
      chk("A.min_leds_0", a_mled, 8'h00);
      wait_t(0, 6000, 20, "A.1:00.00");
      chk("A.min_leds_1", a_mled, 8'h01);

      // Six laps at distinct paused times.
      for (int j = 1; j <= 6; j++) begin
         pulse_ss();
         lapt_a[j] = m_t[0];
         lapt_b[j] = m_t[1];
         pulse_lap();
         if (j == 4) chk("A.four_laps_count", a_cnt, 3'd4);
         if (j == 5) begin
            chk("A.fifth_ignored_count", a_cnt, 3'd4);
            chk("A.fifth_ignored_full", a_full, 1);
         end
         pulse_ss();
         cyc(25);
      end
      chk("B.ring_count", b_cnt, 3'd4);
      chk("B.ring_full", b_full, 1);

      view_en = 1'b1;
      view_sel = 2'd2;
      check_disp(0, lapt_a[3], "A.view2_lap3");
      view_sel = 2'd3;
      check_disp(0, lapt_a[4], "A.view3_lap4");
      check_disp(1, lapt_b[6], "B.view3_lap6");
      view_sel = 2'd0;
      check_disp(1, lapt_b[3], "B.view0_lap3");
      check_disp(0, lapt_a[1], "A.view0_lap1");

      // Lap in the same cycle as a B tick must keep the pre-increment time.
      g = 0;
      while (!(m_st[1] == 1 && m_ph[1] == 1) && g < 20) begin @(negedge clk_50M); g++; end
      chk("B.tick_align", g < 20, 1);
      pre = m_t[1];
      pulse_lap();
      chk("B.tick_happened", m_t[1], (pre + 1) % 12000);
      view_sel = 2'd3;
      check_disp(1, pre, "B.lap_on_tick");

      // clear together with start_stop and lap while running.
      clear = 1'b1; start_stop = 1'b1; lap = 1'b1;
      @(negedge clk_50M);
      clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
      chk("clear.A_running", a_running, 0);
      chk("clear.B_running", b_running, 0);
      chk("clear.A_lap_count", a_cnt, 0);
      chk("clear.B_lap_count", b_cnt, 0);
      chk("clear.B_lap_full", b_full, 0);
      chk("clear.A_min_leds", a_mled, 0);
      chk("clear.model_t", m_t[0], 0);
      view_sel = 2'd0;
      check_disp(0, 0, "clear.A_empty_view");
      view_sel = 2'd3;
      check_disp(1, 0, "clear.B_empty_view");
      view_en = 1'b0;
      check_disp(0, 0, "clear.A_live_idle");
      chk("clear.stays_idle", a_running, 0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

endmodule
